// File: rtl/dec_lut_arb_pkg.sv
// Shared types and default sizing for the decoder-sharing arbiter.
// Holds the FSM state encoding and the default decoder/timeout constants.
package dec_lut_arb_pkg;

  localparam int DEF_NUM_REQ     = 4;
  localparam int DEF_W_BITS      = 69;
  localparam int DEF_N_BITS      = 53;
  localparam int DEF_TIMEOUT_CYC = 255;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } arb_state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dec_lut_arbiter_rr_arbiter.sv
// Round-robin grant picker: first requester at or after last_grant+1 wins.
// Purely combinational; the owner registers last_grant.
module rr_arbiter
  import dec_lut_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = idx_width(DEF_NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last_grant,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_gnt_idx
);

  int w_pos;

  // Scan farthest-first so the nearest candidate after last_grant overwrites.
  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    w_pos     = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_pos = int'(i_last_grant) + k;
      if (w_pos >= NUM_REQ) w_pos = w_pos - NUM_REQ;
      if (i_req[IDX_W'(w_pos)]) begin
        o_gnt                = '0;
        o_gnt[IDX_W'(w_pos)] = 1'b1;
        o_gnt_idx            = IDX_W'(w_pos);
      end
    end
  end

endmodule

// File: rtl/dec_lut_arbiter.sv
// Shares one W->N decoder among NUM_REQ requesters with round-robin grant and timeout.
// Optional job statistics counters are built only when DEC_ARB_STATS_EN is defined.
//
// state | meaning
// IDLE  | waiting for any req_valid; grant and latch the word on acceptance
// CLEAR | decoder held in clear (dec_rst_n=0) for one cycle, timer loaded
// WAIT  | word held on dec_w; wait for dec_found or timer terminal count
// RESP  | result presented to granted requester until it takes it
module dec_lut_arbiter
  import dec_lut_arb_pkg::*;
#(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int W_BITS      = DEF_W_BITS,
  parameter int N_BITS      = DEF_N_BITS,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*W_BITS-1:0] req_w,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [N_BITS-1:0]         rsp_n,
  output logic                      rsp_timeout,
  output logic [W_BITS-1:0]         dec_w,
  output logic                      dec_rst_n,
  input  logic                      dec_found,
  input  logic [N_BITS-1:0]         dec_n,
  output logic [15:0]               stat_done_cnt,
  output logic [15:0]               stat_to_cnt
);

  localparam int IDX_W = idx_width(NUM_REQ);
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

  arb_state_t          r_state, w_state_nxt;
  logic [IDX_W-1:0]    r_last_grant, r_gnt_idx, w_arb_idx;
  logic [NUM_REQ-1:0]  w_arb_gnt;
  logic [CNT_W-1:0]    r_wait_cnt;
  logic [W_BITS-1:0]   r_dec_w;
  logic [N_BITS-1:0]   r_rsp_n;
  logic                r_rsp_timeout;
  logic                w_accept, w_found, w_timeout, w_rsp_take;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .i_req        (req_valid),
    .i_last_grant (r_last_grant),
    .o_gnt        (w_arb_gnt),
    .o_gnt_idx    (w_arb_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_found     = 1'b0;
    w_timeout   = 1'b0;
    w_rsp_take  = 1'b0;
    req_ready   = '0;
    rsp_valid   = '0;
    case (r_state)
      S_IDLE: begin
        if (!rst && (|req_valid)) begin
          w_accept    = 1'b1;
          req_ready   = w_arb_gnt;
          w_state_nxt = S_CLEAR;
        end
      end
      S_CLEAR: w_state_nxt = S_WAIT;
      S_WAIT: begin
        // found in the terminal-count cycle still counts as a decode
        if (dec_found) begin
          w_found     = 1'b1;
          w_state_nxt = S_RESP;
        end else if (r_wait_cnt == '0) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (!rst) rsp_valid[r_gnt_idx] = 1'b1;
        if (rsp_ready[r_gnt_idx]) begin
          w_rsp_take  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant  <= LAST_RST;
      r_gnt_idx     <= '0;
      r_dec_w       <= '0;
      r_rsp_n       <= '0;
      r_rsp_timeout <= 1'b0;
      r_wait_cnt    <= '0;
    end else begin
      if (w_accept) begin
        r_gnt_idx <= w_arb_idx;
        r_dec_w   <= req_w[int'(w_arb_idx)*W_BITS +: W_BITS];
      end
      if (r_state == S_CLEAR) begin
        r_wait_cnt <= CNT_LOAD;
      end else if (r_state == S_WAIT && r_wait_cnt != '0) begin
        r_wait_cnt <= r_wait_cnt - CNT_W'(1);
      end
      if (w_found) begin
        r_rsp_n       <= dec_n;
        r_rsp_timeout <= 1'b0;
      end else if (w_timeout) begin
        r_rsp_n       <= '0;
        r_rsp_timeout <= 1'b1;
      end
      if (w_rsp_take) r_last_grant <= r_gnt_idx;
    end
  end

  assign dec_w       = r_dec_w;
  assign rsp_n       = r_rsp_n;
  assign rsp_timeout = r_rsp_timeout;
  assign dec_rst_n   = ~rst & (r_state != S_CLEAR);

`ifdef DEC_ARB_STATS_EN
  logic [15:0] r_done_cnt, r_to_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_done_cnt <= '0;
      r_to_cnt   <= '0;
    end else begin
      if (w_found && r_done_cnt != 16'hFFFF) r_done_cnt <= r_done_cnt + 16'd1;
      if (w_timeout && r_to_cnt != 16'hFFFF) r_to_cnt <= r_to_cnt + 16'd1;
    end
  end

  assign stat_done_cnt = r_done_cnt;
  assign stat_to_cnt   = r_to_cnt;
`else
  assign stat_done_cnt = '0;
  assign stat_to_cnt   = '0;
`endif

endmodule

// File: tb/tb_dec_lut_arbiter.sv
// Self-checking bench for dec_lut_arbiter: vector table of jobs plus reset-in-WAIT sequence.
module tb_dec_lut_arbiter;

  localparam int NR = 4;
  localparam int WB = 69;
  localparam int NB = 53;
  localparam int TO = 255;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR*WB-1:0]  req_w;
  logic [NR-1:0]     req_ready;
  logic [NR-1:0]     rsp_valid;
  logic [NR-1:0]     rsp_ready;
  logic [NB-1:0]     rsp_n;
  logic              rsp_timeout;
  logic [WB-1:0]     dec_w;
  logic              dec_rst_n;
  logic              dec_found;
  logic [NB-1:0]     dec_n;
  logic [15:0]       stat_done_cnt;
  logic [15:0]       stat_to_cnt;

  dec_lut_arbiter #(
    .NUM_REQ     (NR),
    .W_BITS      (WB),
    .N_BITS      (NB),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_w         (req_w),
    .req_ready     (req_ready),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_n         (rsp_n),
    .rsp_timeout   (rsp_timeout),
    .dec_w         (dec_w),
    .dec_rst_n     (dec_rst_n),
    .dec_found     (dec_found),
    .dec_n         (dec_n),
    .stat_done_cnt (stat_done_cnt),
    .stat_to_cnt   (stat_to_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NR-1:0] mask;
    int            exp_g;
    int            fdelay;   // WAIT cycles before found; -1 = never
    logic [NB-1:0] n;
    int            rdelay;
    bit            hold;
    bit            stale;
  } vec_t;

  typedef struct {
    int            g;
    logic [NB-1:0] n;
    logic          to;
  } exp_t;

  vec_t vecs[11];
  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   exp_done = 0;
  int   exp_to_n = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  function automatic logic [WB-1:0] word_of(input int i, input int seed);
    return {5'(i + 1), 64'hC0FF_EE00_0000_0000 | 64'(seed * 16 + i)};
  endfunction

  task automatic drive_words(input int seed);
    for (int i = 0; i < NR; i++) req_w[i*WB +: WB] = word_of(i, seed);
  endtask

  task automatic set_dec(input bit f, input logic [NB-1:0] n);
    dec_found = f;
    dec_n     = n;
  endtask

  task automatic chk_stats();
`ifdef DEC_ARB_STATS_EN
    chk("stat_done", 128'(stat_done_cnt), 128'(exp_done));
    chk("stat_to", 128'(stat_to_cnt), 128'(exp_to_n));
`else
    chk("stat_done_zero", 128'(stat_done_cnt), 128'(0));
    chk("stat_to_zero", 128'(stat_to_cnt), 128'(0));
`endif
  endtask

  task automatic run_job(input vec_t v, input int seed);
    logic [NR-1:0] exp_oh;
    logic [NR-1:0] got_oh;
    logic [NB-1:0] held_n;
    exp_t          e;
    logic          exp_to;
    int            waitn, lat, exp_lat;
    exp_oh = '0;
    exp_oh[v.exp_g] = 1'b1;
    exp_to = (v.fdelay < 0);
    if (v.stale) set_dec(1'b1, 53'h0BAD_0BAD_0BAD);
    drive_words(seed);
    req_valid = v.mask;
    #1;
    waitn = 0;
    while (req_ready == '0 && waitn < 20) begin
      @(negedge clk); #1;
      waitn++;
    end
    chk("grant", 128'(req_ready), 128'(exp_oh));
    e.g = v.exp_g;
    e.n = exp_to ? '0 : v.n;
    e.to = exp_to;
    sb.push_back(e);
    @(negedge clk);
    chk("clear_pulse", 128'(dec_rst_n), 128'(0));
    chk("ready_pulse", 128'(req_ready), 128'(0));
    if (!v.hold) req_valid = '0;
    @(negedge clk);
    chk("clear_release", 128'(dec_rst_n), 128'(1));
    chk("dec_w", 128'(dec_w), 128'(word_of(v.exp_g, seed)));
    set_dec(v.fdelay == 0, (v.fdelay == 0) ? v.n : ~v.n);
    lat = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (rsp_valid != '0) break;
      if (lat > TO + 20) begin
        n_total++;
        $display("FAIL rsp_wait_bound: no rsp_valid after %0d cycles", lat);
        break;
      end
      chk("dec_w_hold", 128'(dec_w), 128'(word_of(v.exp_g, seed)));
      chk("single_job", 128'(req_ready), 128'(0));
      set_dec(v.fdelay == lat, (v.fdelay == lat) ? v.n : ~v.n);
    end
    set_dec(1'b0, '0);
    exp_lat = exp_to ? TO : v.fdelay + 1;
    chk("latency", 128'(lat), 128'(exp_lat));
    chk("rsp_valid", 128'(rsp_valid), 128'(exp_oh));
    held_n = rsp_n;
    for (int r = 0; r < v.rdelay; r++) begin
      rsp_ready = ~exp_oh;
      @(negedge clk);
      chk("hold_valid", 128'(rsp_valid), 128'(exp_oh));
      chk("hold_n", 128'(rsp_n), 128'(held_n));
      chk("no_regrant", 128'(req_ready), 128'(0));
    end
    rsp_ready = exp_oh;
    #1;
    if (sb.size() == 0) begin
      n_total++;
      $display("FAIL scoreboard: response with empty queue");
    end else begin
      e = sb.pop_front();
      got_oh = '0;
      got_oh[e.g] = 1'b1;
      chk("rsp_idx", 128'(rsp_valid), 128'(got_oh));
      chk("rsp_n", 128'(rsp_n), 128'(e.n));
      chk("rsp_timeout", 128'(rsp_timeout), 128'(e.to));
      if (e.to) exp_to_n++;
      else      exp_done++;
    end
    @(negedge clk);
    rsp_ready = '0;
    chk("rsp_drop", 128'(rsp_valid), 128'(0));
    chk_stats();
  endtask

  initial begin
    vecs[0]  = '{4'b1111, 0, 2,      53'h11,                 0,  1'b1, 1'b0};
    vecs[1]  = '{4'b1111, 1, 1,      53'h22,                 1,  1'b1, 1'b0};
    vecs[2]  = '{4'b1111, 2, 4,      53'h33,                 0,  1'b1, 1'b0};
    vecs[3]  = '{4'b1111, 3, 0,      53'h44,                 0,  1'b1, 1'b0};
    vecs[4]  = '{4'b1111, 0, 3,      53'h55,                 0,  1'b1, 1'b0};
    vecs[5]  = '{4'b0001, 0, 10,     53'd4503599627370495,   0,  1'b0, 1'b0};
    vecs[6]  = '{4'b0001, 0, 0,      53'h1234_5678_9ABC,     2,  1'b0, 1'b0};
    vecs[7]  = '{4'b1010, 1, 3,      53'h0F0F_0F0F_0F0F0,    20, 1'b0, 1'b0};
    vecs[8]  = '{4'b1010, 3, -1,     53'h0,                  1,  1'b0, 1'b0};
    vecs[9]  = '{4'b0110, 1, 5,      53'h1555_5555_5555,     0,  1'b0, 1'b1};
    vecs[10] = '{4'b0110, 2, TO - 1, 53'h1ABCDE,             0,  1'b0, 1'b0};

    rst = 1'b1;
    req_valid = '0;
    req_w = '0;
    rsp_ready = '0;
    set_dec(1'b0, '0);
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 128'(req_ready), 128'(0));
    chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
    chk("rst_rsp_n", 128'(rsp_n), 128'(0));
    chk("rst_dec_w", 128'(dec_w), 128'(0));
    chk("rst_dec_rst_n", 128'(dec_rst_n), 128'(0));
    rst = 1'b0;
    #1;
    chk("rst_release_dec_rst_n", 128'(dec_rst_n), 128'(1));
    @(negedge clk);

    for (int j = 0; j < 11; j++) run_job(vecs[j], j + 1);

    // reset while the decoder is busy
    drive_words(50);
    req_valid = 4'b0010;
    #1;
    chk("pre_rst_grant", 128'(req_ready), 128'(4'b0010));
    @(negedge clk);
    req_valid = '0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    req_valid = 4'b1111;
    #1;
    chk("rst_in_wait_dec_rst_n", 128'(dec_rst_n), 128'(0));
    chk("rst_in_wait_no_ready", 128'(req_ready), 128'(0));
    @(negedge clk);
    chk("mid_rst_req_ready", 128'(req_ready), 128'(0));
    chk("mid_rst_rsp_valid", 128'(rsp_valid), 128'(0));
    chk("mid_rst_rsp_n", 128'(rsp_n), 128'(0));
    chk("mid_rst_rsp_timeout", 128'(rsp_timeout), 128'(0));
    chk("mid_rst_dec_w", 128'(dec_w), 128'(0));
    chk("mid_rst_dec_rst_n", 128'(dec_rst_n), 128'(0));
    exp_done = 0;
    exp_to_n = 0;
    chk_stats();
    req_valid = '0;
    rst = 1'b0;
    #1;
    chk("mid_rst_release", 128'(dec_rst_n), 128'(1));
    @(negedge clk);
    run_job('{4'b0100, 2, 7, 53'h0DEC_0DED, 0, 1'b0, 1'b0}, 60);

    chk("sb_empty", 128'(sb.size()), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
